// File: rtl/aho_corasick_engine.sv
// aho_corasick_engine: table-programmable Aho-Corasick string matcher.
// One symbol is accepted per READY/EN handshake. The engine then walks the
// goto/failure links held in register tables and reports each match with a
// pattern mask and the text position of the completing symbol.
// Optional feature: define AC_MATCH_CNT_EN to add a saturating MATCH_CNT output.
module aho_corasick_engine #(
  parameter int SYM_W    = 4,
  parameter int STATE_W  = 4,
  parameter int NPAT     = 4,
  parameter int POS_W    = 8,
  parameter int MAX_HOPS = 15
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      INITIALIZE,
  input  logic [SYM_W-1:0]          STRING,
  output logic                      READY,
  input  logic                      CFG_WE,
  input  logic [1:0]                CFG_SEL,
  input  logic [STATE_W+SYM_W-1:0]  CFG_ADDR,
  input  logic [NPAT+STATE_W:0]     CFG_DATA,
  output logic                      MATCH,
  output logic [NPAT-1:0]           MATCH_MASK,
  output logic [POS_W-1:0]          MATCH_POS,
  output logic [STATE_W-1:0]        CUR_STATE,
`ifdef AC_MATCH_CNT_EN
  output logic [15:0]               MATCH_CNT,
`endif
  output logic                      HOP_ERR
);

  localparam int NSTATES = 1 << STATE_W;
  localparam int NENT    = 1 << (STATE_W + SYM_W);
  localparam int HOP_W   = (MAX_HOPS < 1) ? 1 : $clog2(MAX_HOPS + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOOKUP = 1'b1
  } fsm_t;

  // Automaton tables, indexed {state,symbol} for goto and by state otherwise
  logic                goto_valid [NENT];
  logic [STATE_W-1:0]  goto_next  [NENT];
  logic [STATE_W-1:0]  fail_tab   [NSTATES];
  logic [NPAT-1:0]     out_tab    [NSTATES];

  fsm_t                state_q, state_d;
  logic [STATE_W-1:0]  cur_q, cur_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic [POS_W-1:0]    pos_cnt_q, pos_cnt_d;
  logic [POS_W-1:0]    pos_lat_q, pos_lat_d;
  logic [HOP_W-1:0]    hop_q, hop_d;
  logic                hop_err_q, hop_err_d;
  logic                match_q, match_d;
  logic [NPAT-1:0]     mask_q, mask_d;
  logic [POS_W-1:0]    mpos_q, mpos_d;
  logic                leave;

  logic                      cfg_ok;
  logic [STATE_W-1:0]        cfg_state;
  logic [STATE_W+SYM_W-1:0]  lookup_idx;
  logic                      unused_cfg_bits;

  // Tables only change while the engine idles, so a lookup never sees a half-written walk
  assign cfg_ok          = CFG_WE && (state_q == IDLE) && !INITIALIZE;
  assign cfg_state       = CFG_ADDR[STATE_W-1:0];
  assign lookup_idx      = {cur_q, sym_q};
  assign unused_cfg_bits = ^CFG_DATA;

  // Host table writes; reset clears every goto valid bit, fail link and out mask
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NENT; i++) begin
        goto_valid[i] <= 1'b0;
        goto_next[i]  <= '0;
      end
      for (int i = 0; i < NSTATES; i++) begin
        fail_tab[i] <= '0;
        out_tab[i]  <= '0;
      end
    end else if (cfg_ok) begin
      case (CFG_SEL)
        2'd0: begin
          goto_valid[CFG_ADDR] <= CFG_DATA[STATE_W];
          goto_next[CFG_ADDR]  <= CFG_DATA[STATE_W-1:0];
        end
        2'd1:    fail_tab[cfg_state] <= CFG_DATA[STATE_W-1:0];
        2'd2:    out_tab[cfg_state]  <= CFG_DATA[NPAT-1:0];
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan datapath registers: automaton state, position, hop count and match outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cur_q     <= '0;
      sym_q     <= '0;
      pos_cnt_q <= '0;
      pos_lat_q <= '0;
      hop_q     <= '0;
      hop_err_q <= 1'b0;
      match_q   <= 1'b0;
      mask_q    <= '0;
      mpos_q    <= '0;
    end else begin
      cur_q     <= cur_d;
      sym_q     <= sym_d;
      pos_cnt_q <= pos_cnt_d;
      pos_lat_q <= pos_lat_d;
      hop_q     <= hop_d;
      hop_err_q <= hop_err_d;
      match_q   <= match_d;
      mask_q    <= mask_d;
      mpos_q    <= mpos_d;
    end
  end

  // Next-state logic: accept a symbol, then follow goto or failure links until resolved
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    sym_d     = sym_q;
    pos_cnt_d = pos_cnt_q;
    pos_lat_d = pos_lat_q;
    hop_d     = hop_q;
    hop_err_d = hop_err_q;
    match_d   = 1'b0;
    mask_d    = '0;
    mpos_d    = mpos_q;
    leave     = 1'b0;

    if (INITIALIZE) begin
      state_d   = IDLE;
      cur_d     = '0;
      pos_cnt_d = '0;
      hop_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (EN) begin
            sym_d     = STRING;
            pos_lat_d = pos_cnt_q;
            pos_cnt_d = pos_cnt_q + POS_W'(1);
            hop_d     = '0;
            state_d   = LOOKUP;
          end
        end
        LOOKUP: begin
          if (goto_valid[lookup_idx]) begin
            cur_d   = goto_next[lookup_idx];
            state_d = IDLE;
            leave   = 1'b1;
          end else if (cur_q == '0) begin
            state_d = IDLE;
            leave   = 1'b1;
          end else if (hop_q == HOP_W'(MAX_HOPS)) begin
            cur_d     = '0;
            hop_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cur_d = fail_tab[cur_q];
            hop_d = hop_q + HOP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (leave && (out_tab[cur_d] != '0)) begin
      match_d = 1'b1;
      mask_d  = out_tab[cur_d];
      mpos_d  = pos_lat_q;
    end
  end

  assign READY      = (state_q == IDLE);
  assign MATCH      = match_q;
  assign MATCH_MASK = mask_q;
  assign MATCH_POS  = mpos_q;
  assign CUR_STATE  = cur_q;
  assign HOP_ERR    = hop_err_q;

`ifdef AC_MATCH_CNT_EN
  logic [15:0] match_cnt_q;

  // Saturating count of match pulses, restarted with the text scan
  always_ff @(posedge CLK) begin
    if (!RST) begin
      match_cnt_q <= '0;
    end else if (INITIALIZE) begin
      match_cnt_q <= '0;
    end else if (match_d && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_q <= match_cnt_q + 16'd1;
    end
  end

  assign MATCH_CNT = match_cnt_q;
`endif

endmodule

// File: doc/aho_corasick_engine.md
Name: aho_corasick_engine

Overview:
- Parametrised, table-programmable Aho-Corasick string matcher; successor to the fixed 4-bit-symbol TOP matcher.
- Consumes one symbol per handshake from the STRING stream and walks goto/failure links held in internal register tables.
- Reports every match with a pattern bitmask and the text position.
- Sits between the text source (symbol stream) and the match consumer; tables are loaded by the host through a config write port before scanning.

Parameters:
SYM_W, 4, symbol width; 2^SYM_W goto entries per state
STATE_W, 4, state index width; NSTATES = 2^STATE_W; state 0 is root
NPAT, 4, number of patterns; one mask bit each
POS_W, 8, text position counter width
MAX_HOPS, 15, failure-link hop limit per symbol

Ports:
CLK  in  1  clock, all logic rising edge
RST  in  1  synchronous active-low reset
EN  in  1  symbol valid
INITIALIZE  in  1  synchronous restart of text scan (root, pos 0)
STRING  in  SYM_W  input symbol
READY  out  1  engine can accept a symbol
CFG_WE  in  1  table write strobe
CFG_SEL  in  2  0=goto, 1=fail, 2=out, 3=reserved (write ignored)
CFG_ADDR  in  STATE_W+SYM_W  goto: {state,sym}; fail/out: low STATE_W bits = state
CFG_DATA  in  NPAT+STATE_W+1  goto: [STATE_W]=valid, [STATE_W-1:0]=next; fail: [STATE_W-1:0]; out: [NPAT-1:0]
MATCH  out  1  one-cycle match pulse
MATCH_MASK  out  NPAT  patterns ending at MATCH_POS; 0 when MATCH=0
MATCH_POS  out  POS_W  position of the symbol that completed the match
CUR_STATE  out  STATE_W  current automaton state
HOP_ERR  out  1  sticky: hop limit exceeded

Behaviour:
- Reset (RST=0 at edge): FSM=IDLE, CUR_STATE=0, position=0, READY=1, MATCH=0, MATCH_MASK=0, MATCH_POS=0, HOP_ERR=0. All goto valid bits, fail entries and out masks are cleared.
- FSM states:
  - IDLE (READY=1): on EN=1, latch STRING, latch position, increment position (wraps 2^POS_W-1 -> 0), clear hop count, go to LOOKUP.
  - LOOKUP (READY=0): if goto[cur][sym].valid, cur=next, go to IDLE. Else if cur==0, stay at 0, go to IDLE. Else cur=fail[cur], hop++, remain in LOOKUP.
  - On leaving LOOKUP, if out[new cur] != 0: MATCH=1 for one cycle with MATCH_MASK=out[new cur] and MATCH_POS=latched position. Otherwise MATCH=0 and MATCH_MASK=0.
- Latency:
  - Direct goto or root self-loop: MATCH/CUR_STATE valid 1 cycle after the accept edge.
  - Each failure hop adds 1 cycle.
  - Maximum throughput: 1 symbol per 2 cycles.
- Hop limit: if hop reaches MAX_HOPS while still in LOOKUP, force cur=0, set HOP_ERR, return to IDLE, no MATCH. HOP_ERR clears only on reset.
- Out masks are loaded pre-merged along failure chains; the engine does not OR the outputs of fail ancestors.
- INITIALIZE=1 (sync, any state): cur=0, position=0, FSM=IDLE, no MATCH that cycle. An in-flight symbol is abandoned. If EN is also asserted, INITIALIZE wins and the symbol is dropped.
- Config:
  - CFG_WE honoured only when the FSM is in IDLE and INITIALIZE=0; otherwise the write is dropped silently.
  - Writes take effect for the next accepted symbol.
  - A CFG_WE coincident with an EN accept is honoured before that symbol's lookup.
- Reset mid-scan: reset wins over everything, including INITIALIZE and CFG_WE.

Optional Feature:
- Macro AC_MATCH_CNT_EN.
- When defined: adds output MATCH_CNT[15:0], a saturating count of MATCH pulses (holds at 16'hFFFF). Cleared by reset and by INITIALIZE.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Program patterns he/she/his/hers with symbol map h=1, e=2, s=3, i=4, r=5, u=6:
  - States: 1=h, 2=he, 3=s, 4=sh, 5=she, 6=hi, 7=his, 8=her, 9=hers.
  - Fail links: 5->2, 4->1, 7->3, 9->3, others ->0.
  - Out masks: out2=0001, out5=0011, out7=0100, out9=1000.
  - Then stream "ushers" (6,3,1,2,5,3) -> MATCH at pos 3 mask 0011, MATCH at pos 5 mask 1000. Symbol 'r' takes 2 LOOKUP cycles (one hop 5->2->8).
- Stream "his" from reset-programmed tables -> MATCH pos 2 mask 0100; CUR_STATE=7.
- Assert INITIALIZE together with EN after "sh" -> symbol dropped, CUR_STATE=0, next 'e' gives no MATCH, position restarts at 0.
- Program fail 1->1 self-loop with MAX_HOPS=15, send h then 2 -> HOP_ERR=1 after 15 hops, CUR_STATE=0, READY returns.
- Send 300 root-only symbols (u) with POS_W=8 -> position wraps 255->0; a following "he" reports MATCH_POS 45.
- With AC_MATCH_CNT_EN defined, run "ushers" twice -> MATCH_CNT=4; pulse INITIALIZE -> MATCH_CNT=0.
